// File: rtl/svnet_multiport_ram.sv
// svnet_multiport_ram: lane-masked single-write, multi-read RAM that zeroes itself after reset
// Optional feature macro: SVNET_RAM_BYPASS_EN (stage-1 write forwarding to every read port)
// Ports:
//   clk, rst_n                 clock and async active-low reset
//   ready                      high once the post-reset clear has finished
//   write, write_address,
//   write_strobe, write_data   write request with per-lane enables
//   read, read_address         per-port read requests
//   read_data_valid, read_data per-port registered read results (data holds when not valid)
module svnet_multiport_ram #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   parameter int READ_PORTS = 2,
   parameter int LANE_WIDTH = 8,
   localparam int AW = $clog2(DEPTH),
   localparam int LANES = WIDTH / LANE_WIDTH
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   output logic                                 ready,
   input  logic                                 write,
   input  logic [AW-1:0]                        write_address,
   input  logic [LANES-1:0]                     write_strobe,
   input  logic [WIDTH-1:0]                     write_data,
   input  logic [READ_PORTS-1:0]                read,
   input  logic [READ_PORTS-1:0][AW-1:0]        read_address,
   output logic [READ_PORTS-1:0]                read_data_valid,
   output logic [READ_PORTS-1:0][WIDTH-1:0]     read_data
);
   typedef enum logic {CLEAR, READY} state_t;
   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
   state_t state, next_state;
   logic [AW-1:0] clear_addr;
   logic [WIDTH-1:0] ram [DEPTH];
   logic write_q;
   logic [AW-1:0] write_address_q;
   logic [LANES-1:0] write_strobe_q;
   logic [WIDTH-1:0] write_data_q;
   logic [READ_PORTS-1:0] read_q;
   logic [READ_PORTS-1:0][AW-1:0] read_address_q;
   logic [WIDTH-1:0] mask;
   logic [READ_PORTS-1:0][WIDTH-1:0] rd_word;
   logic out_of_range;
   function automatic logic in_range(input logic [AW-1:0] a);
      return {1'b0, a} < DEPTH_W;
   endfunction
   assign ready = (state == READY);
   always_comb next_state = (state == CLEAR && clear_addr == LAST) ? READY : state;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= CLEAR;
         clear_addr <= '0;
      end else begin
         state <= next_state;
         clear_addr <= (state == CLEAR) ? clear_addr + 1'b1 : clear_addr;
      end
   end
   // Requests arriving before the clear completes are dropped here, so they never reach the array.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         write_q <= 1'b0;
         write_address_q <= '0;
         write_strobe_q <= '0;
         write_data_q <= '0;
         read_q <= '0;
         read_address_q <= '0;
      end else begin
         write_q <= write & ready;
         if (write && ready) begin
            write_address_q <= write_address;
            write_strobe_q <= write_strobe;
            write_data_q <= write_data;
         end
         read_q <= read & {READ_PORTS{ready}};
         for (int p = 0; p < READ_PORTS; p++)
            if (read[p] && ready) read_address_q[p] <= read_address[p];
      end
   end
   always_comb begin
      mask = '0;
      for (int l = 0; l < LANES; l++) mask[l*LANE_WIDTH +: LANE_WIDTH] = {LANE_WIDTH{write_strobe_q[l]}};
   end
   always_ff @(posedge clk) begin
      if (state == CLEAR)
         ram[clear_addr] <= '0;
      else if (write_q && in_range(write_address_q))
         ram[write_address_q] <= (ram[write_address_q] & ~mask) | (write_data_q & mask);
   end
   always_comb begin
      rd_word = '0;
      for (int p = 0; p < READ_PORTS; p++) begin
         rd_word[p] = in_range(read_address_q[p]) ? ram[read_address_q[p]] : '0;
`ifdef SVNET_RAM_BYPASS_EN
         // Same-cycle write to the same word: merge its strobed lanes over the stored word.
         if (write_q && write_address_q == read_address_q[p] && in_range(write_address_q))
            rd_word[p] = (rd_word[p] & ~mask) | (write_data_q & mask);
`endif
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         read_data_valid <= '0;
         read_data <= '0;
      end else begin
         read_data_valid <= read_q;
         for (int p = 0; p < READ_PORTS; p++)
            if (read_q[p]) read_data[p] <= rd_word[p];
      end
   end
   always_comb begin
      out_of_range = write_q & ~in_range(write_address_q);
      for (int p = 0; p < READ_PORTS; p++)
         out_of_range = out_of_range | (read_q[p] & ~in_range(read_address_q[p]));
   end
   assert property (@(posedge clk) disable iff (!rst_n) !out_of_range);
endmodule

// File: tb/tb_svnet_multiport_ram.sv
// tb_svnet_multiport_ram: random and directed checks of svnet_multiport_ram against a word-array model
module tb_svnet_multiport_ram;
   localparam int W = 16, D = 16, P = 2, LW = 8, AW = 4, L = 2;
   logic clk = 1'b0, rst_n = 1'b0;
   logic ready, write;
   logic [AW-1:0] write_address;
   logic [L-1:0] write_strobe;
   logic [W-1:0] write_data;
   logic [P-1:0] read, read_data_valid;
   logic [P-1:0][AW-1:0] read_address;
   logic [P-1:0][W-1:0] read_data;
   int checks = 0, fails = 0;
   logic [W-1:0] mem [D];
   int cnt;
   logic [P-1:0] pv, ev;
   logic [W-1:0] pd [P];
   logic [W-1:0] ed [P];
   logic acc;
   svnet_multiport_ram #(.WIDTH(W), .DEPTH(D), .READ_PORTS(P), .LANE_WIDTH(LW)) dut (
      .clk(clk), .rst_n(rst_n), .ready(ready), .write(write), .write_address(write_address),
      .write_strobe(write_strobe), .write_data(write_data), .read(read), .read_address(read_address),
      .read_data_valid(read_data_valid), .read_data(read_data));
   always #5 clk = ~clk;
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   task automatic model_reset();
      for (int a = 0; a < D; a++) mem[a] = '0;
      cnt = 0;
      pv = '0;
      ev = '0;
      for (int p = 0; p < P; p++) begin
         pd[p] = '0;
         ed[p] = '0;
      end
   endtask
   task automatic model_write();
      if (acc && write)
         for (int l = 0; l < L; l++)
            if (write_strobe[l]) mem[write_address][l*LW +: LW] = write_data[l*LW +: LW];
   endtask
   // Reads accepted at an edge appear one edge later; reads see every earlier write,
   // and with forwarding also the write accepted at the same edge.
   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) model_reset();
         else begin
            ev = pv;
            for (int p = 0; p < P; p++) if (pv[p]) ed[p] = pd[p];
            acc = (cnt >= D);
`ifdef SVNET_RAM_BYPASS_EN
            model_write();
`endif
            for (int p = 0; p < P; p++) begin
               pv[p] = acc & read[p];
               if (pv[p]) pd[p] = mem[read_address[p]];
            end
`ifndef SVNET_RAM_BYPASS_EN
            model_write();
`endif
            if (cnt < D) cnt++;
         end
      end
   end
   always @(negedge clk) begin
      check("ready", 32'(ready), 32'(cnt >= D));
      for (int p = 0; p < P; p++) begin
         check($sformatf("valid%0d", p), 32'(read_data_valid[p]), 32'(ev[p]));
         check($sformatf("data%0d", p), 32'(read_data[p]), 32'(ed[p]));
      end
   end
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic idle();
      write = 1'b0;
      read = '0;
   endtask
   task automatic wr(input logic [AW-1:0] a, input logic [L-1:0] s, input logic [W-1:0] d);
      write = 1'b1;
      write_address = a;
      write_strobe = s;
      write_data = d;
   endtask
   task automatic randomize_inputs();
      write = 1'($urandom_range(0, 1));
      write_address = AW'($urandom_range(0, D - 1));
      write_strobe = L'($urandom);
      write_data = W'($urandom);
      read = P'($urandom);
      for (int p = 0; p < P; p++) read_address[p] = AW'($urandom_range(0, D - 1));
   endtask
   initial begin
      idle();
      write_address = '0;
      write_strobe = '0;
      write_data = '0;
      read_address = '0;
      repeat (3) step();
      rst_n = 1'b1;
      repeat (15) step();
      check("ready_after_15", 32'(ready), 32'd0);
      step();
      check("ready_after_16", 32'(ready), 32'd1);
      for (int a = 0; a < D; a++) begin
         read = 2'b11;
         read_address[0] = AW'(a);
         read_address[1] = AW'(D - 1 - a);
         step();
      end
      idle();
      repeat (2) step();
      wr(3, 2'b11, 16'h00A5);
      step();
      idle();
      read = 2'b11;
      read_address[0] = 3;
      read_address[1] = 3;
      step();
      idle();
      step();
      check("t2_valid", 32'(read_data_valid), 32'h3);
      check("t2_data0", 32'(read_data[0]), 32'h00A5);
      check("t2_data1", 32'(read_data[1]), 32'h00A5);
      wr(5, 2'b11, 16'h003C);
      read = 2'b01;
      read_address[0] = 5;
      step();
      idle();
      step();
`ifdef SVNET_RAM_BYPASS_EN
      check("t3_same_cycle", 32'(read_data[0]), 32'h003C);
`else
      check("t3_same_cycle", 32'(read_data[0]), 32'h0000);
`endif
      wr(7, 2'b11, 16'h1234);
      step();
      wr(7, 2'b10, 16'hFFFF);
      step();
      idle();
      read = 2'b01;
      read_address[0] = 7;
      step();
      idle();
      step();
      check("t4_lane_merge", 32'(read_data[0]), 32'hFF34);
      wr(1, 2'b11, 16'h1111);
      step();
      wr(2, 2'b11, 16'h2222);
      step();
      idle();
      read = 2'b11;
      read_address[0] = 1;
      read_address[1] = 2;
      repeat (2) step();
      check("t5_valid", 32'(read_data_valid), 32'h3);
      check("t5_data0", 32'(read_data[0]), 32'h1111);
      check("t5_data1", 32'(read_data[1]), 32'h2222);
      repeat (6) step();
      idle();
      repeat (2) step();
      repeat (400) begin
         randomize_inputs();
         step();
      end
      idle();
      read = 2'b11;
      step();
      step();
      check("t6_valid_before", 32'(read_data_valid), 32'h3);
      rst_n = 1'b0;
      #1;
      check("t6_valid_async", 32'(read_data_valid), 32'h0);
      check("t6_ready_async", 32'(ready), 32'h0);
      idle();
      step();
      rst_n = 1'b1;
      repeat (5) step();
      rst_n = 1'b0;
      #1;
      check("t6_ready_midclear", 32'(ready), 32'h0);
      step();
      rst_n = 1'b1;
      repeat (15) begin
         randomize_inputs();
         step();
      end
      check("t6_ready_after_15", 32'(ready), 32'd0);
      step();
      check("t6_ready_after_16", 32'(ready), 32'd1);
      idle();
      read = 2'b11;
      read_address[0] = 3;
      read_address[1] = 7;
      repeat (2) step();
      check("t6_cleared0", 32'(read_data[0]), 32'h0);
      check("t6_cleared1", 32'(read_data[1]), 32'h0);
      repeat (150) begin
         randomize_inputs();
         step();
      end
      idle();
      repeat (3) step();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
